// File: rtl/shiftreg_univ.sv
//------------------------------------------------------------------------------
// shiftreg_univ : universal shift register with a WIDTH-bit serial burst mode
// Optional: SHIFTREG_UNIV_PARITY_EN adds combinational output par.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shiftreg_univ #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  output logic             sout,
  output logic [WIDTH-1:0] pout,
  output logic             busy,
  output logic             done
`ifdef SHIFTREG_UNIV_PARITY_EN
  ,
  output logic             par
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] c_MODE_HOLD  = 3'b000;
  localparam logic [2:0] c_MODE_SHL   = 3'b001;
  localparam logic [2:0] c_MODE_SHR   = 3'b010;
  localparam logic [2:0] c_MODE_LOAD  = 3'b011;
  localparam logic [2:0] c_MODE_ROL   = 3'b100;
  localparam logic [2:0] c_MODE_ROR   = 3'b101;
  localparam logic [2:0] c_MODE_ASR   = 3'b110;
  localparam logic [2:0] c_MODE_HOLD2 = 3'b111;

  localparam logic [CW-1:0] c_CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_pout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_idle_next;
  logic             w_sout;

  always_comb begin
    w_idle_next = r_pout;
    case (mode)
      c_MODE_HOLD:  w_idle_next = r_pout;
      c_MODE_SHL:   w_idle_next = {r_pout[WIDTH-2:0], sin};
      c_MODE_SHR:   w_idle_next = {sin, r_pout[WIDTH-1:1]};
      c_MODE_LOAD:  w_idle_next = pin;
      c_MODE_ROL:   w_idle_next = {r_pout[WIDTH-2:0], r_pout[WIDTH-1]};
      c_MODE_ROR:   w_idle_next = {r_pout[0], r_pout[WIDTH-1:1]};
      c_MODE_ASR:   w_idle_next = {r_pout[WIDTH-1], r_pout[WIDTH-1:1]};
      c_MODE_HOLD2: w_idle_next = r_pout;
      default:      w_idle_next = r_pout;
    endcase
  end

  // Serial output taps whichever end the current operation shifts out of.
  always_comb begin
    w_sout = 1'b0;
    if (r_busy) begin
      w_sout = r_pout[0];
    end else begin
      case (mode)
        c_MODE_SHL, c_MODE_ROL:             w_sout = r_pout[WIDTH-1];
        c_MODE_SHR, c_MODE_ROR, c_MODE_ASR: w_sout = r_pout[0];
        default:                            w_sout = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pout <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_pout <= {sin, r_pout[WIDTH-1:1]};
      r_done <= 1'b0;
      if (r_cnt == c_CNT_ONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt - c_CNT_ONE;
      end
    end else if (start) begin
      r_pout <= pin;
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_cnt  <= c_CNT_FULL;
    end else begin
      r_pout <= w_idle_next;
      r_done <= 1'b0;
    end
  end

  assign pout = r_pout;
  assign busy = r_busy;
  assign done = r_done;
  assign sout = w_sout;

`ifdef SHIFTREG_UNIV_PARITY_EN
  assign par = ^r_pout;
`endif

endmodule

`default_nettype wire

// File: doc/shiftreg_univ.md
SHIFTREG_UNIV -- requirements
Module: shiftreg_univ

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mode  input  3  operation select when idle (see Function).
REQ-005 sin  input  1  serial data in.
REQ-006 pin  input  WIDTH  parallel load data.
REQ-007 start  input  1  burst request; sampled only when idle.
REQ-008 sout  output  1  serial data out, combinational from pout/mode/busy.
REQ-009 pout  output  WIDTH  register contents, registered.
REQ-010 busy  output  1  burst in progress, registered.
REQ-011 done  output  1  one-cycle burst-complete pulse, registered.

Function
REQ-012 Idle (busy=0, start=0) mode decode per edge: 000 hold; 001 shift left, sin->pout[0]; 010 shift right, sin->pout[WIDTH-1]; 011 pout<=pin; 100 rotate left; 101 rotate right; 110 arithmetic shift right, pout[WIDTH-1] retained, sin ignored; 111 hold.
REQ-013 start=1 while idle SHALL take priority over mode: pout<=pin, busy<=1, internal count<=WIDTH.
REQ-014 Internal count width SHALL be $clog2(WIDTH+1) bits; unsigned, no wrap.
REQ-015 While busy: mode and pin ignored; each edge shifts right (sin->pout[WIDTH-1]) and decrements count.
REQ-016 Edge performing the WIDTH-th burst shift SHALL clear busy and set done; busy high exactly WIDTH cycles.
REQ-017 done SHALL be high for exactly one cycle, the cycle after busy falls, and low otherwise.
REQ-018 start while busy SHALL be ignored (no restart, no queueing).
REQ-019 start on the cycle done=1 (busy=0) SHALL begin a new burst; done still deasserts next edge.
REQ-020 sout: busy -> pout[0]; idle mode 001/100 -> pout[WIDTH-1]; idle mode 010/101/110 -> pout[0]; otherwise 0.
REQ-021 Burst transmit order: pin[0] first, pin[WIDTH-1] last on sout; first received sin bit ends in pout[0] at burst end.

Reset
REQ-022 rst=1 at posedge clk SHALL force pout=0, busy=0, done=0, count=0, overriding start and mode.
REQ-023 rst asserted mid-burst SHALL abort the burst with no done pulse.
REQ-024 sout after reset SHALL follow REQ-020 with pout=0, i.e. 0.

Configuration
REQ-025 Macro SHIFTREG_UNIV_PARITY_EN defined: extra output par (1 bit) = XOR reduction of pout, combinational.
REQ-026 Macro undefined: port par SHALL not exist; all other behaviour identical.

Verification
REQ-027 WIDTH=8, rst 1 cycle, mode=011 pin=8'hA5 -> next cycle pout=8'hA5, sout=0; mode=000 for 3 cycles -> pout stays 8'hA5.
REQ-028 pout=8'h81, mode=100 one edge -> pout=8'h03, sout=0; mode=101 two edges -> pout=8'hC0, sout=0.
REQ-029 pout=8'h90, mode=110 two edges -> pout=8'hE4; mode=001 sin=1 one edge -> pout=8'hC9, sout=1.
REQ-030 start=1 pin=8'h3C, sin stream 1,0,1,1,0,0,1,0 -> busy 8 cycles, sout=0,0,1,1,1,1,0,0, then done 1 cycle, pout=8'h4D.
REQ-031 start re-pulsed at cycle 3 of a burst -> ignored, busy still 8 cycles; rst at cycle 5 -> pout=0, busy=0, no done.
REQ-032 With SHIFTREG_UNIV_PARITY_EN, pout=8'h07 -> par=1; pout=8'h0F -> par=0.
